ssd_display_driver: RTL and testbench

SSD_DISPLAY_DRIVER -- requirements
Module: ssd_display_driver

---
 rtl/ssd_display_driver_if.sv | 25 ++
 rtl/ssd_display_driver.sv | 142 ++++++++++++++
 tb/tb_ssd_display_driver.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ssd_display_driver_if.sv
// Display driver bundle: value to show plus scan outputs and status.
// The processor side is the master; the driver is the slave.
interface ssd_display_driver_if;
   logic [12:0] num;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic        busy;
   logic        bcd_valid;

   modport master (
      output num,
      input  anode,
      input  seg,
      input  busy,
      input  bcd_valid
   );

   modport slave (
      input  num,
      output anode,
      output seg,
      output busy,
      output bcd_valid
   );
endinterface

// File: rtl/ssd_display_driver.sv
// 4-digit multiplexed 7-segment driver with serial double-dabble conversion.
// Define SSD_LEADING_ZERO_BLANK_EN to blank non-significant leading zeros.
module ssd_display_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic                clk,
   input  logic                rst,
   ssd_display_driver_if.slave ssd
);

   localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [12:0] r_last_num;
   logic [12:0] r_bin;
   logic [15:0] r_bcd;
   logic [15:0] w_adj;
   logic [15:0] r_digits;
   logic [3:0]  r_cnt;
   logic [DW-1:0] r_div;
   logic [1:0]  r_idx;
   logic [3:0]  r_anode;
   logic [6:0]  r_seg;
   logic [3:0]  w_nib;
   logic        w_blank;

   function automatic logic [6:0] f_seg(input logic [3:0] n);
      case (n)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = 7'b1111111;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (ssd.num != r_last_num) w_next = LOAD;
         LOAD:    w_next = SHIFT;
         SHIFT:   if (r_cnt == 4'd12) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // add-3 correction applied before every shift
   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < 4; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_num <= '0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_digits   <= '0;
      end else begin
         case (r_state)
            LOAD: begin
               r_last_num <= ssd.num;
               r_bin      <= ssd.num;
               r_bcd      <= '0;
               r_cnt      <= '0;
            end
            SHIFT: begin
               {r_bcd, r_bin} <= {w_adj[14:0], r_bin, 1'b0};
               r_cnt          <= r_cnt + 4'd1;
            end
            DONE:    r_digits <= r_bcd;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (r_idx)
         2'd0:    w_nib = r_digits[3:0];
         2'd1:    w_nib = r_digits[7:4];
         2'd2:    w_nib = r_digits[11:8];
         default: w_nib = r_digits[15:12];
      endcase
   end

`ifdef SSD_LEADING_ZERO_BLANK_EN
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd3: w_blank = (r_digits[15:12] == 4'd0);
         2'd2: w_blank = (r_digits[15:8] == 8'd0);
         2'd1: w_blank = (r_digits[15:4] == 12'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   // the wrap edge drives the current slot and advances the index together
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div   <= '0;
         r_idx   <= '0;
         r_anode <= 4'b1111;
         r_seg   <= 7'b1111111;
      end else if (r_div == DIV_MAX) begin
         r_div   <= '0;
         r_idx   <= r_idx + 2'd1;
         r_anode <= ~(4'b0001 << r_idx);
         r_seg   <= w_blank ? 7'b1111111 : f_seg(w_nib);
      end else begin
         r_div   <= r_div + 1'b1;
      end
   end

   assign ssd.anode     = r_anode;
   assign ssd.seg       = r_seg;
   assign ssd.busy      = (r_state != IDLE);
   assign ssd.bcd_valid = (r_state == DONE);

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver (REFRESH_DIV 4 main, 2 scan-only).
// Expected segment codes are hand-written constants.
module tb_ssd_display_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ssd_display_driver_if bus ();
   ssd_display_driver_if bus2 ();
   assign bus2.num = bus.num;

   ssd_display_driver #(.REFRESH_DIV(4)) u_dut (
      .clk(clk), .rst(rst), .ssd(bus)
   );
   ssd_display_driver #(.REFRESH_DIV(2)) u_dut2 (
      .clk(clk), .rst(rst), .ssd(bus2)
   );

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] LZ = BL;
`else
   localparam logic [6:0] LZ = S0;
`endif

   int n_chk = 0;
   int n_bad = 0;
   int vcnt  = 0;
   int bcnt  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (bus.bcd_valid) vcnt++;
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic wait_valid(input int target, input int lim);
      int k = 0;
      while (vcnt < target && k < lim) begin
         step(1);
         k++;
      end
      chk("vwait", vcnt, target);
   endtask

   function automatic int slot_of(input logic [3:0] an);
      case (an)
         4'b1110: slot_of = 0;
         4'b1101: slot_of = 1;
         4'b1011: slot_of = 2;
         4'b0111: slot_of = 3;
         default: slot_of = -1;
      endcase
   endfunction

   task automatic scan(input string tag, input logic [6:0] e3,
                       input logic [6:0] e2, input logic [6:0] e1,
                       input logic [6:0] e0);
      logic [6:0] s [4];
      int sl;
      for (int i = 0; i < 4; i++) s[i] = 7'hx;
      for (int i = 0; i < 32; i++) begin
         step(1);
         sl = slot_of(bus.anode);
         if (sl < 0) chk({tag, "_onehot"}, bus.anode, 4'b1110);
         else s[sl] = bus.seg;
      end
      chk({tag, "_d0"}, s[0], e0);
      chk({tag, "_d1"}, s[1], e1);
      chk({tag, "_d2"}, s[2], e2);
      chk({tag, "_d3"}, s[3], e3);
   endtask

   initial begin
      logic [3:0] prev;
      logic [6:0] e7 [4];
      int k;
      int sl;
      int changes;

      bus.num = 13'd0;
      rst = 1'b1;
      step(2);
      chk("rst_anode", bus.anode, 4'b1111);
      chk("rst_seg", bus.seg, BL);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_valid", bus.bcd_valid, 1'b0);

      rst = 1'b0;
      vcnt = 0;
      bcnt = 0;
      k = 0;
      while (bus.anode == 4'b1111 && k < 10) begin
         step(1);
         k++;
      end
      chk("first_anode", bus.anode, 4'b1110);
      chk("first_seg", bus.seg, S0);
      chk("idle_busy", bcnt, 0);

      vcnt = 0;
      bcnt = 0;
      bus.num = 13'd1234;
      step(40);
      chk("c1234_busy", bcnt, 15);
      chk("c1234_valid", vcnt, 1);
      scan("n1234", S1, S2, S3, S4);

      vcnt = 0;
      bcnt = 0;
      bus.num = 13'd8191;
      step(40);
      chk("c8191_valid", vcnt, 1);
      scan("n8191", S8, S1, S9, S1);

      vcnt = 0;
      e7[0] = S7;
      e7[1] = LZ;
      e7[2] = LZ;
      e7[3] = LZ;
      bus.num = 13'd7;
      step(5);
      bus.num = 13'd42;
      wait_valid(1, 40);
      step(1);
      prev = bus.anode;
      for (int i = 0; i < 15; i++) begin
         step(1);
         if (bus.anode != prev) begin
            sl = slot_of(bus.anode);
            if (sl < 0) chk("n7_onehot", bus.anode, 4'b1110);
            else chk("n7_seg", bus.seg, e7[sl]);
            prev = bus.anode;
         end
      end
      wait_valid(2, 40);
      step(20);
      chk("n42_valid", vcnt, 2);
      scan("n42", LZ, LZ, S4, S2);

      vcnt = 0;
      bus.num = 13'd999;
      step(5);
      chk("abort_busy", bus.busy, 1'b1);
      rst = 1'b1;
      step(1);
      chk("abort_anode", bus.anode, 4'b1111);
      chk("abort_seg", bus.seg, BL);
      chk("abort_busyoff", bus.busy, 1'b0);
      bus.num = 13'd0;
      step(1);
      rst = 1'b0;
      bcnt = 0;
      step(20);
      chk("abort_valid", vcnt, 0);
      chk("zero_nobusy", bcnt, 0);
      scan("n0", LZ, LZ, LZ, S0);

      vcnt = 0;
      rst = 1'b1;
      bus.num = 13'd5;
      step(1);
      rst = 1'b0;
      step(1);
      chk("rel_start", bus.busy, 1'b1);
      step(30);
      chk("n5_valid", vcnt, 1);
      scan("n5", LZ, LZ, LZ, S5);

      changes = 0;
      prev = bus2.anode;
      for (int i = 0; i < 16; i++) begin
         step(1);
         chk("d2_onelow", $countones(~bus2.anode), 1);
         if (bus2.anode != prev) begin
            chk("d2_rot", bus2.anode, {prev[2:0], prev[3]});
            changes++;
            prev = bus2.anode;
         end
      end
      chk("d2_changes", changes, 8);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
